// File: rtl/div_ctrl.sv
// Issue-side sequencer for RV32M DIV/DIVU/REM/REMU around an unsigned iterative divider core.
// Converts operands to magnitudes, resolves divide-by-zero and overflow locally, and sign-corrects results.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  input  logic            i_ack,
  output logic            o_core_start,
  output logic [XLEN-1:0] o_core_a,
  output logic [XLEN-1:0] o_core_b,
  input  logic            i_core_done,
  input  logic [XLEN-1:0] i_core_quo,
  input  logic [XLEN-1:0] i_core_rem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;

  logic            signed_op;
  logic            sgn_a;
  logic            sgn_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] core_res;

  // funct3[0]=0 selects the signed variants; -2^31 negates to itself, which is its correct unsigned magnitude.
  assign signed_op = ~i_op[0];
  assign sgn_a     = signed_op & i_rs1[XLEN-1];
  assign sgn_b     = signed_op & i_rs2[XLEN-1];
  assign mag_a     = sgn_a ? -i_rs1 : i_rs1;
  assign mag_b     = sgn_b ? -i_rs2 : i_rs2;
  assign div_zero  = (i_rs2 == '0);
  assign overflow  = signed_op & (i_rs1 == MIN_NEG) & (i_rs2 == '1);

  assign core_res = is_rem ? (neg_r ? -i_core_rem : i_core_rem)
                           : (neg_q ? -i_core_quo : i_core_quo);

  assign o_ready = (state == S_IDLE);

  // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= S_IDLE;
      is_rem       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_core_start <= 1'b0;
      o_core_a     <= '0;
      o_core_b     <= '0;
    end else begin
      o_core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid && !i_kill) begin
            is_rem   <= i_op[1];
            neg_q    <= sgn_a ^ sgn_b;
            neg_r    <= sgn_a;
            o_core_a <= mag_a;
            o_core_b <= mag_b;
            if (div_zero) begin
              o_result <= i_op[1] ? i_rs1 : '1;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end else if (overflow) begin
              o_result <= i_op[1] ? '0 : MIN_NEG;
              o_valid  <= 1'b1;
              state    <= S_DONE;
            end else begin
              o_core_start <= 1'b1;
              state        <= S_START;
            end
          end
        end
        // Once the start pulse is out the core is busy, so a kill must wait for its done pulse.
        S_START: state <= i_kill ? S_DRAIN : S_WAIT;
        S_WAIT: begin
          if (i_kill) begin
            state <= i_core_done ? S_IDLE : S_DRAIN;
          end else if (i_core_done) begin
            o_result <= core_res;
            o_valid  <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_kill || i_ack) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (i_core_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: drives the core handshake by hand and scores results through an expected-value queue.
module tb_div_ctrl;

  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_valid = 1'b0;
  logic [1:0]      i_op = 2'b00;
  logic [XLEN-1:0] i_rs1 = '0;
  logic [XLEN-1:0] i_rs2 = '0;
  logic            i_kill = 1'b0;
  logic            o_ready;
  logic            o_valid;
  logic [XLEN-1:0] o_result;
  logic            i_ack = 1'b0;
  logic            o_core_start;
  logic [XLEN-1:0] o_core_a;
  logic [XLEN-1:0] o_core_b;
  logic            i_core_done = 1'b0;
  logic [XLEN-1:0] i_core_quo = '0;
  logic [XLEN-1:0] i_core_rem = '0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  int n_checks  = 0;
  int n_errors  = 0;
  int start_cnt = 0;
  logic [XLEN-1:0] exp_q[$];

  div_ctrl #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_kill(i_kill), .o_ready(o_ready),
    .o_valid(o_valid), .o_result(o_result), .i_ack(i_ack),
    .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_b(o_core_b),
    .i_core_done(i_core_done), .i_core_quo(i_core_quo), .i_core_rem(i_core_rem)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_core_start) start_cnt++;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one op for a single cycle, then scramble the operand bus to prove operands were latched.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit push, input logic [XLEN-1:0] exp);
    check("ready_at_issue", {31'b0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    if (push) exp_q.push_back(exp);
    tick();
    i_valid = 1'b0;
    i_op    = 2'($urandom_range(0, 3));
    i_rs1   = $urandom;
    i_rs2   = $urandom;
  endtask

  task automatic core_done(input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem);
    i_core_done = 1'b1;
    i_core_quo  = quo;
    i_core_rem  = rem;
    tick();
    i_core_done = 1'b0;
    i_core_quo  = $urandom;
    i_core_rem  = $urandom;
  endtask

  // Bounded wait for o_valid, then score the result against the oldest expected value.
  task automatic collect(input string tag);
    logic [XLEN-1:0] exp;
    for (int i = 0; i < 20 && !o_valid; i++) tick();
    check({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
    if (o_valid) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~o_result;
      check({tag, "_result"}, o_result, exp);
    end
  endtask

  task automatic ack();
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("valid_after_ack", {31'b0, o_valid}, 32'd0);
  endtask

  initial begin
    int s0;

    // Reset state
    #2;
    check("rst_valid",  {31'b0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_start",  {31'b0, o_core_start}, 32'd0);
    check("rst_core_a", o_core_a, 32'd0);
    check("rst_core_b", o_core_b, 32'd0);
    check("rst_ready",  {31'b0, o_ready}, 32'd1);
    tick();
    i_rst = 1'b1;
    tick();

    // DIV -7 / 2 -> -3
    s0 = start_cnt;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
    check("div_start", {31'b0, o_core_start}, 32'd1);
    check("div_core_a", o_core_a, 32'd7);
    check("div_core_b", o_core_b, 32'd2);
    check("div_ready_busy", {31'b0, o_ready}, 32'd0);
    tick();
    check("div_start_1cyc", {31'b0, o_core_start}, 32'd0);
    tick();
    core_done(32'd3, 32'd1);
    collect("div_neg");
    check("div_one_pulse", start_cnt - s0, 32'd1);
    ack();
    check("ready_after_ack", {31'b0, o_ready}, 32'd1);

    // REM -7 / 2 -> -1
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
    tick();
    core_done(32'd3, 32'd1);
    collect("rem_neg");
    ack();

    // REMU 0xFFFF_FFF9 / 2 -> 1, operands unchanged
    issue(OP_REMU, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'd1);
    check("remu_core_a", o_core_a, 32'hFFFF_FFF9);
    tick();
    core_done(32'h7FFF_FFFC, 32'd1);
    collect("remu");
    ack();

    // Divide-by-zero: result at T+1, core never started
    s0 = start_cnt;
    issue(OP_DIVU, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF);
    check("divu0_t1", {31'b0, o_valid}, 32'd1);
    collect("divu0");
    ack();
    issue(OP_REM, 32'd5, 32'd0, 1'b1, 32'd5);
    check("rem0_t1", {31'b0, o_valid}, 32'd1);
    collect("rem0");
    ack();

    // Signed overflow
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
    check("ovf_div_t1", {31'b0, o_valid}, 32'd1);
    collect("ovf_div");
    ack();
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
    collect("ovf_rem");
    ack();
    check("special_no_start", start_cnt - s0, 32'd0);

    // Kill on the accept cycle discards the op
    s0 = start_cnt;
    i_kill = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd3, 1'b0, '0);
    i_kill = 1'b0;
    check("kill_accept_ready", {31'b0, o_ready}, 32'd1);
    tick();
    check("kill_accept_nostart", start_cnt - s0, 32'd0);

    // Kill two cycles into WAIT, then a delayed core done drains the core
    issue(OP_DIVU, 32'd50, 32'd5, 1'b0, '0);
    tick();
    tick();
    tick();
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    check("drain_ready0", {31'b0, o_ready}, 32'd0);
    tick();
    tick();
    check("drain_ready0_late", {31'b0, o_ready}, 32'd0);
    check("drain_novalid", {31'b0, o_valid}, 32'd0);
    core_done(32'd10, 32'd0);
    check("drain_idle", {31'b0, o_ready}, 32'd1);
    check("drain_no_result", {31'b0, o_valid}, 32'd0);

    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14);
    tick();
    core_done(32'd14, 32'd2);
    collect("divu_after_drain");
    ack();

    // Core done outside WAIT/DRAIN is ignored
    core_done(32'h1234, 32'h5678);
    check("stray_done", {31'b0, o_valid}, 32'd0);

    // Kill in DONE drops the result
    issue(OP_DIVU, 32'd8, 32'd0, 1'b0, '0);
    i_kill = 1'b1;
    tick();
    i_kill = 1'b0;
    check("kill_done", {31'b0, o_valid}, 32'd0);
    check("kill_done_idle", {31'b0, o_ready}, 32'd1);

    // Result held stable without ack: DIV 20 / -3 -> -6
    issue(OP_DIV, 32'd20, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFA);
    check("hold_core_b", o_core_b, 32'd3);
    tick();
    core_done(32'd6, 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'b0, o_valid}, 32'd1);
      check("hold_result", o_result, 32'hFFFF_FFFA);
      tick();
    end
    collect("hold");
    ack();

    // Asynchronous reset mid-WAIT
    issue(OP_DIVU, 32'd77, 32'd7, 1'b0, '0);
    tick();
    #2;
    i_rst = 1'b0;
    #1;
    check("arst_start",  {31'b0, o_core_start}, 32'd0);
    check("arst_core_a", o_core_a, 32'd0);
    check("arst_core_b", o_core_b, 32'd0);
    check("arst_valid",  {31'b0, o_valid}, 32'd0);
    check("arst_result", o_result, 32'd0);
    #3;
    i_rst = 1'b1;
    tick();
    core_done(32'd11, 32'd0);
    check("arst_idle", {31'b0, o_ready}, 32'd1);
    check("arst_no_valid", {31'b0, o_valid}, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer for the RV32M divide instructions DIV, DIVU, REM and REMU.
- Sits between the execute-stage issue handshake and an unsigned iterative divider core.
- Handles operand sign conversion, divide-by-zero and signed overflow, result sign correction, quotient/remainder selection, and pipeline kill.
- The core only ever sees non-negative operands.

Parameters:
XLEN, 32, operand/result width (only 32 supported)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_valid  in  1  issue request; operands and op valid
i_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
i_rs1  in  XLEN  dividend
i_rs2  in  XLEN  divisor
i_kill  in  1  squash in-flight op (pipeline flush)
o_ready  out  1  controller can accept an op this cycle
o_valid  out  1  o_result valid
o_result  out  XLEN  final architectural result
i_ack  in  1  consumer takes o_result
o_core_start  out  1  one-cycle start pulse to core
o_core_a  out  XLEN  unsigned magnitude of dividend
o_core_b  out  XLEN  unsigned magnitude of divisor
i_core_done  in  1  one-cycle pulse: core quotient/remainder valid
i_core_quo  in  XLEN  unsigned quotient
i_core_rem  in  XLEN  unsigned remainder

Behaviour:
- Reset (i_rst=0, async) forces:
  - state IDLE.
  - o_valid=0, o_core_start=0, o_result=0, o_core_a=0, o_core_b=0.
  - All internal registers cleared.
- States:
  - IDLE: o_ready=1. On i_valid, capture op, sign flags, both magnitudes and special-case flags.
    - Divisor==0 or signed overflow goes to DONE.
    - Otherwise goes to START.
  - START: o_core_start=1 for exactly one cycle, o_core_a/o_core_b stable; next state WAIT.
  - WAIT: on i_core_done, compute and register o_result, go to DONE.
  - DONE: o_valid=1, o_result held stable until i_ack; on i_ack go to IDLE.
  - DRAIN: entered on i_kill while in START or WAIT; o_ready=0 and the core result is discarded; on i_core_done go to IDLE.
- o_ready=1 only in IDLE. An accept is i_valid & o_ready.
- Kill handling:
  - i_kill in IDLE or DONE returns to IDLE with o_valid=0 next cycle.
  - i_kill on the accept cycle discards the op.
  - i_kill has priority over i_ack and i_core_done in the same cycle. In WAIT with i_core_done, that pair goes to IDLE, since the core is already free.
- Sign handling:
  - Signed ops (DIV, REM): magnitude = two's complement negation if bit31=1. −2^31 maps to 0x8000_0000 unsigned.
  - Unsigned ops (DIVU, REMU): operands passed unchanged.
- Result correction:
  - DIV: quotient negated iff sign(rs1) XOR sign(rs2).
  - REM: remainder negated iff sign(rs1)=1.
  - Unsigned ops: no correction.
- Special cases (core not started; result valid in DONE the cycle after accept):
  - Divisor 0: DIV/DIVU give 0xFFFF_FFFF; REM/REMU give rs1.
  - Signed overflow, DIV/REM only with rs1=0x8000_0000 and rs2=0xFFFF_FFFF: DIV gives 0x8000_0000, REM gives 0.
- Latency:
  - Accept at cycle T: START at T+1, core done at T+1+N, o_valid at T+2+N.
  - Special cases: o_valid at T+1.
- Back-to-back: the earliest next accept is the cycle after i_ack.
- i_core_done outside WAIT/DRAIN is ignored.
- Operands are latched at accept; later changes on i_rs1/i_rs2/i_op have no effect.

Test Plan:
- DIV −7 / 2, core returns quo 3 rem 1 -> o_result 0xFFFF_FFFD; o_core_a=7, o_core_b=2; one o_core_start pulse.
- REM −7 / 2, and REMU 0xFFFF_FFF9 / 2 -> 0xFFFF_FFFF and 0x0000_0001 (core quo 0x7FFF_FFFC) respectively.
- DIVU 5 / 0 and REM 5 / 0 -> 0xFFFF_FFFF and 5 at T+1; o_core_start never asserted.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000, with o_valid at T+1.
- i_kill two cycles into WAIT -> o_ready=0 until the delayed i_core_done, then IDLE with no o_valid. The next DIVU 100/7 returns 14.
- o_valid held 3 cycles with i_ack=0 -> o_result stable. Reset asserted mid-WAIT -> all outputs 0 asynchronously and state IDLE after release.
